// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/redirect controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_defs;

  // Bit positions in stall_o/bubble_o. Each name is the stage that register feeds.
  // PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
  localparam int PC_S      = 0;
  localparam int ID_S      = 1;
  localparam int EX_S      = 2;
  localparam int MEM_S     = 3;
  localparam int WB_S      = 4;
  localparam int STAGE_NUM = 5;

  typedef logic [STAGE_NUM-1:0] stage_vec_t;

  // IDLE: no redirect owed. PEND: a branch target is waiting for the PC to unfreeze.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-to-controller bundle: stall requests and redirects in, hold/bubble/redirect out.
// Latency: n/a (wires only).
// Backpressure: n/a.
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 32
);
  import pipe_ctrl_defs::*;

  logic              if_stallreq_i;
  logic              id_stallreq_i;
  logic              ex_stallreq_i;
  logic              mem_stallreq_i;
  logic              id_branch_flag_i;
  logic [ADDR_W-1:0] id_branch_tgt_i;
  logic              excp_flush_i;
  logic [ADDR_W-1:0] excp_tgt_i;
  stage_vec_t        stall_o;
  stage_vec_t        bubble_o;
  logic              redirect_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              if_id_instr_invalid_o;
  logic              hang_o;

  // Pipeline side: raises requests, obeys hold/bubble/redirect.
  modport master (
    output if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i,
    output id_branch_flag_i, id_branch_tgt_i, excp_flush_i, excp_tgt_i,
    input  stall_o, bubble_o, redirect_o, redirect_pc_o, if_id_instr_invalid_o, hang_o
  );

  // Controller side.
  modport slave (
    input  if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i,
    input  id_branch_flag_i, id_branch_tgt_i, excp_flush_i, excp_tgt_i,
    output stall_o, bubble_o, redirect_o, redirect_pc_o, if_id_instr_invalid_o, hang_o
  );

endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky hang flag at TIMEOUT.
// Latency: hang_o registers on the same edge the count reaches TIMEOUT.
// Backpressure: none; observes stall activity only.
module stall_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any_i,
  output logic hang_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hang_q, hang_d;

  // Count stalled cycles, saturating; any free-running cycle restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    hang_d = hang_q;
    if (!stall_any_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_MAX) begin
      hang_d = 1'b1;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hang_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hang_q <= hang_d;
    end
  end

  assign hang_o = hang_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall merge, branch/exception redirect sequencing and wrong-path fetch squash for the 5-stage pipe.
// Latency: stall/bubble/redirect are combinational; a branch seen while the PC is held redirects on PC release.
// Backpressure: a branch presented while IF/ID is held is ignored and must be re-presented by ID.
module pipeline_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int ADDR_W        = 32,
  parameter int SQUASH_CYCLES = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  ctl
);

  localparam int SQ_W = $clog2(SQUASH_CYCLES + 1);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [SQ_W-1:0]   squash_q, squash_d;

  stage_vec_t        stall, bubble;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              branch_acc;
  logic              hang;

  // Stall merge: the deepest requesting stage holds everything upstream of it and
  // bubbles the register just downstream. Exceptions override and flush everything.
  always_comb begin
    stall  = '0;
    bubble = '0;
    if (rst) begin
      stall  = '0;
      bubble = '0;
    end else if (ctl.excp_flush_i) begin
      bubble = '1;
      bubble[PC_S] = 1'b0;
    end else if (ctl.mem_stallreq_i) begin
      stall[PC_S]  = 1'b1;
      stall[ID_S]  = 1'b1;
      stall[EX_S]  = 1'b1;
      stall[MEM_S] = 1'b1;
      bubble[WB_S] = 1'b1;
    end else if (ctl.ex_stallreq_i) begin
      stall[PC_S]   = 1'b1;
      stall[ID_S]   = 1'b1;
      stall[EX_S]   = 1'b1;
      bubble[MEM_S] = 1'b1;
    end else if (ctl.id_stallreq_i) begin
      stall[PC_S]  = 1'b1;
      stall[ID_S]  = 1'b1;
      bubble[EX_S] = 1'b1;
    end else if (ctl.if_stallreq_i) begin
      stall[PC_S]  = 1'b1;
      bubble[ID_S] = 1'b1;
    end
  end

  assign branch_acc = ctl.id_branch_flag_i & ~stall[ID_S];

  // Redirect FSM: exception wins; otherwise a taken branch redirects now if the PC
  // is free, else its target is parked until the PC unfreezes.
  always_comb begin
    state_d     = state_q;
    pend_tgt_d  = pend_tgt_q;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (!rst) begin
      if (ctl.excp_flush_i) begin
        redirect    = 1'b1;
        redirect_pc = ctl.excp_tgt_i;
        state_d     = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (branch_acc) begin
              if (!stall[PC_S]) begin
                redirect    = 1'b1;
                redirect_pc = ctl.id_branch_tgt_i;
              end else begin
                pend_tgt_d = ctl.id_branch_tgt_i;
                state_d    = PEND;
              end
            end
          end
          PEND: begin
            // ID only holds the wrong-path NOP here, so any branch flag is stale.
            if (!stall[PC_S]) begin
              redirect    = 1'b1;
              redirect_pc = pend_tgt_q;
              state_d     = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Squash counter: reloaded (not accumulated) by every redirect, then counts down
  // one per fetch slot actually consumed while the PC advances.
  always_comb begin
    squash_d = squash_q;
    if (redirect) begin
      squash_d = SQ_LOAD;
    end else if ((squash_q != '0) && !stall[PC_S]) begin
      squash_d = squash_q - 1'b1;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_tgt_q <= '0;
      squash_q   <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      squash_q   <= squash_d;
    end
  end

  stall_watchdog #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .stall_any_i (|stall),
    .hang_o      (hang)
  );

  assign ctl.stall_o               = stall;
  assign ctl.bubble_o              = bubble;
  assign ctl.redirect_o            = redirect;
  assign ctl.redirect_pc_o         = redirect_pc;
  assign ctl.if_id_instr_invalid_o = ~rst & (redirect | (squash_q != '0));
  assign ctl.hang_o                = ~rst & hang;

endmodule
